// File: rtl/ram_loader_pkg.sv
// Shared definitions for the RAM program loader: sequencer state encoding and byte width.
package ram_loader_pkg;

  localparam int unsigned BYTE_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RECV   = 3'd1,
    ST_WRITE  = 3'd2,
    ST_CHECK  = 3'd3,
    ST_FINISH = 3'd4
  } loader_state_t;

endpackage

// File: rtl/ram_loader_word_assembler.sv
// Big-endian byte-to-word assembler for ram_loader; with LOADER_CHECKSUM_EN it also
// keeps the running 8-bit sum of assembled bytes.
module loader_word_assembler
  import ram_loader_pkg::*;
#(
  parameter int unsigned BYTES_PER_WORD = 2
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 i_clear,
  input  logic                                 i_accept,
  input  logic [BYTE_WIDTH-1:0]                i_byte,
  output logic [BYTES_PER_WORD*BYTE_WIDTH-1:0] o_word,
  output logic                                 o_word_valid
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [BYTE_WIDTH-1:0]                o_sum
`endif
);

  localparam int unsigned WORD_WIDTH = BYTES_PER_WORD * BYTE_WIDTH;
  localparam int unsigned CNT_W      = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

  logic [CNT_W-1:0]      cnt_q;
  logic [WORD_WIDTH-1:0] word_q;
  logic                  last_byte;

  assign last_byte    = (cnt_q == CNT_W'(BYTES_PER_WORD - 1));
  assign o_word_valid = i_accept && last_byte;
  assign o_word       = word_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else if (i_clear) begin
      cnt_q <= '0;
    end else if (i_accept) begin
      // Shift-left insert keeps the first byte in the MSB position.
      word_q <= (word_q << BYTE_WIDTH) | WORD_WIDTH'(i_byte);
      cnt_q  <= last_byte ? '0 : cnt_q + CNT_W'(1);
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_sum <= '0;
    end else if (i_clear) begin
      o_sum <= '0;
    end else if (i_accept) begin
      o_sum <= o_sum + i_byte;
    end
  end
`endif

endmodule

// File: rtl/ram_loader.sv
// Program loader and RAM write-port arbiter: holds the CPU, streams bytes into RAM from
// address 0, then releases the CPU. Optional LOADER_CHECKSUM_EN adds a trailing check byte.
module ram_loader
  import ram_loader_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 16,
  parameter int unsigned RAM_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_clk_en,
  input  logic                     i_start,
  input  logic [ADDRESS_WIDTH:0]   i_length,
  input  logic                     i_byte_valid,
  input  logic [7:0]               i_byte_data,
  output logic                     o_byte_ready,
  input  logic [ADDRESS_WIDTH-1:0] i_cpu_address,
  input  logic                     i_cpu_we,
  input  logic [RAM_WIDTH-1:0]     i_cpu_data,
  output logic [ADDRESS_WIDTH-1:0] o_ram_address,
  output logic                     o_ram_we,
  output logic [RAM_WIDTH-1:0]     o_ram_data,
  output logic                     o_cpu_hold,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_error
);

  localparam int unsigned BYTES_PER_WORD = RAM_WIDTH / BYTE_WIDTH;

`ifdef LOADER_CHECKSUM_EN
  localparam loader_state_t AFTER_LAST = ST_CHECK;
  logic [BYTE_WIDTH-1:0] byte_sum;
  logic                  error_q;
`else
  localparam loader_state_t AFTER_LAST = ST_FINISH;
`endif

  loader_state_t          state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [ADDRESS_WIDTH:0]   remaining_q;
  logic                     hold_q;
  logic                     zero_done_q;
  logic                     start_ok, load_start, byte_accept, commit, last_word;
  logic [RAM_WIDTH-1:0]     word;
  logic                     word_valid;

  assign start_ok     = (state_q == ST_IDLE) && i_start;
  assign load_start   = start_ok && (i_length != '0);
  assign o_byte_ready = (state_q == ST_RECV) || (state_q == ST_CHECK);
  assign byte_accept  = i_byte_valid && o_byte_ready;
  assign commit       = (state_q == ST_WRITE) && i_clk_en;
  assign last_word    = (remaining_q == (ADDRESS_WIDTH + 1)'(1));
  assign o_cpu_hold   = hold_q;
  assign o_busy       = (state_q != ST_IDLE);
  assign o_done       = (state_q == ST_FINISH) || zero_done_q;

  loader_word_assembler #(
    .BYTES_PER_WORD(BYTES_PER_WORD)
  ) u_assembler (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (start_ok),
    .i_accept    (byte_accept && (state_q == ST_RECV)),
    .i_byte      (i_byte_data),
    .o_word      (word),
    .o_word_valid(word_valid)
`ifdef LOADER_CHECKSUM_EN
    ,
    .o_sum       (byte_sum)
`endif
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    o_ram_address = i_cpu_address;
    o_ram_we      = i_cpu_we;
    o_ram_data    = i_cpu_data;
    case (state_q)
      ST_IDLE:   if (load_start) state_d = ST_RECV;
      ST_RECV:   if (word_valid) state_d = ST_WRITE;
      ST_WRITE:  if (i_clk_en) state_d = last_word ? AFTER_LAST : ST_RECV;
      ST_CHECK:  if (byte_accept) state_d = ST_FINISH;
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (state_q != ST_IDLE) begin
      o_ram_address = addr_q;
      o_ram_we      = (state_q == ST_WRITE);
      o_ram_data    = word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      remaining_q <= '0;
      hold_q      <= 1'b1;
      zero_done_q <= 1'b0;
    end else begin
      zero_done_q <= start_ok && (i_length == '0);
      if (start_ok) begin
        addr_q      <= '0;
        remaining_q <= i_length;
        hold_q      <= load_start;
      end else if (commit) begin
        addr_q      <= addr_q + ADDRESS_WIDTH'(1);
        remaining_q <= remaining_q - (ADDRESS_WIDTH + 1)'(1);
      end else if (state_q == ST_FINISH) begin
        // A failed checksum keeps the CPU parked on the suspect image.
        hold_q <= o_error;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      error_q <= 1'b0;
    end else if (start_ok) begin
      error_q <= 1'b0;
    end else if ((state_q == ST_CHECK) && byte_accept &&
                 (i_byte_data != BYTE_WIDTH'(8'h00 - byte_sum))) begin
      error_q <= 1'b1;
    end
  end
  assign o_error = error_q;
`else
  assign o_error = 1'b0;
`endif

endmodule
